// File: rtl/qracc_pkg.sv
// Shared QRAcc types and sizing constants used by the activation buffer
// and the controller's address arithmetic.
package qracc_pkg;

    // Elements per internal access; also the number of activation banks.
    localparam int ACTBUF_INT_ELEMS = 16;
    // Total activation elements held by the buffer.
    localparam int ACTBUF_DEPTH     = 4096;

    // Sticky activation-buffer error flags.
    typedef struct packed {
        logic oob;
        logic collision;
    } actbuf_err_t;

endpackage

// File: rtl/qracc_actbuf_bank.sv
// One activation bank: ROWS x DATA_W storage, two registered read-first
// read ports and two write ports. Port A (int side) overrides port B
// (ext side) when both hit the same row; different rows both commit,
// since an unaligned int write and an ext write can land in one bank
// on different rows in the same cycle.
module qracc_actbuf_bank #(
    parameter int  DATA_W = 8,
    parameter int  ROWS   = 256,
    localparam int RAW    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wa_en_i,
    input  logic [RAW-1:0]    wa_row_i,
    input  logic [DATA_W-1:0] wa_data_i,
    input  logic              wb_en_i,
    input  logic [RAW-1:0]    wb_row_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ra_en_i,
    input  logic [RAW-1:0]    ra_row_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic              rb_en_i,
    input  logic [RAW-1:0]    rb_row_i,
    output logic [DATA_W-1:0] rb_data_o
);

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] ra_q;
    logic [DATA_W-1:0] rb_q;

    // Storage write: port B first so port A wins a same-row clash.
    always_ff @(posedge clk) begin
        if (wb_en_i) mem_q[wb_row_i] <= wb_data_i;
        if (wa_en_i) mem_q[wa_row_i] <= wa_data_i;
    end

    // Registered reads; sample pre-write contents and hold when idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ra_q <= '0;
            rb_q <= '0;
        end else begin
            if (ra_en_i) ra_q <= mem_q[ra_row_i];
            if (rb_en_i) rb_q <= mem_q[rb_row_i];
        end
    end

    assign ra_data_o = ra_q;
    assign rb_data_o = rb_q;

endmodule

// File: rtl/qracc_activation_buffer.sv
// Banked activation buffer. Ext port streams bus words in/out; int port
// does unaligned INT_ELEMS-wide reads/writes spread over all banks.
// Element e lives in bank e%INT_ELEMS, row e/INT_ELEMS.
module qracc_activation_buffer
    import qracc_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  EXT_W     = 32,
    parameter int  INT_ELEMS = ACTBUF_INT_ELEMS,
    parameter int  DEPTH     = ACTBUF_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        clear,
    input  logic                        ext_wr_en,
    input  logic [AW-1:0]               ext_wr_addr,
    input  logic [EXT_W-1:0]            ext_wr_data,
    input  logic                        ext_rd_en,
    input  logic [AW-1:0]               ext_rd_addr,
    output logic [EXT_W-1:0]            ext_rd_data,
    output logic                        ext_rd_valid,
    input  logic                        int_rd_en,
    input  logic [AW-1:0]               int_rd_addr,
    output logic [INT_ELEMS*DATA_W-1:0] int_rd_data,
    output logic                        int_rd_valid,
    input  logic                        int_wr_en,
    input  logic [AW-1:0]               int_wr_addr,
    input  logic [INT_ELEMS*DATA_W-1:0] int_wr_data,
    output actbuf_err_t                 err_o
);

    localparam int EXT_ELEMS = EXT_W / DATA_W;
    localparam int LG        = $clog2(INT_ELEMS);
    localparam int EXT_LG    = $clog2(EXT_ELEMS);
    localparam int EXT_IW    = (EXT_LG > 0) ? EXT_LG : 1;
    localparam int ROWS      = DEPTH / INT_ELEMS;
    localparam int RAW       = $clog2(ROWS);
    // Wide enough for an ext word address scaled to elements plus width,
    // so the range check can never alias.
    localparam int EW        = AW + EXT_LG + 1;
    localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);

    // Lane (element offset within the access) that bank b serves.
    function automatic logic [LG-1:0] lane_of(input logic [LG-1:0] s_lo, input int b);
        return LG'(b) - s_lo;
    endfunction

    // Row that bank b serves: (start + lane) / INT_ELEMS.
    function automatic logic [RAW-1:0] row_of(input logic [EW-1:0] s, input logic [LG-1:0] k);
        logic [EW-1:0] e;
        e = (s + EW'(k)) >> LG;
        return RAW'(e);
    endfunction

    // Element start addresses and range checks.
    logic [EW-1:0] ext_wr_s, ext_rd_s, int_wr_s, int_rd_s;
    logic          ext_wr_oob, ext_rd_oob, int_wr_oob, int_rd_oob;
    logic          ext_wr_ok, int_wr_ok;
    logic          ext_rd_go, int_rd_go;

    assign ext_wr_s   = EW'(ext_wr_addr) << EXT_LG;
    assign ext_rd_s   = EW'(ext_rd_addr) << EXT_LG;
    assign int_wr_s   = EW'(int_wr_addr);
    assign int_rd_s   = EW'(int_rd_addr);

    assign ext_wr_oob = (ext_wr_s + EW'(EXT_ELEMS)) > DEPTH_E;
    assign ext_rd_oob = (ext_rd_s + EW'(EXT_ELEMS)) > DEPTH_E;
    assign int_wr_oob = (int_wr_s + EW'(INT_ELEMS)) > DEPTH_E;
    assign int_rd_oob = (int_rd_s + EW'(INT_ELEMS)) > DEPTH_E;

    // Out-of-range writes are dropped whole; clear kills same-cycle reads.
    assign ext_wr_ok  = ext_wr_en && !ext_wr_oob;
    assign int_wr_ok  = int_wr_en && !int_wr_oob;
    assign ext_rd_go  = ext_rd_en && !clear;
    assign int_rd_go  = int_rd_en && !clear;

    logic [EXT_ELEMS-1:0][DATA_W-1:0] ext_wr_vec;
    logic [INT_ELEMS-1:0][DATA_W-1:0] int_wr_vec;
    logic [INT_ELEMS-1:0][DATA_W-1:0] bank_ext_q;
    logic [INT_ELEMS-1:0][DATA_W-1:0] bank_int_q;
    logic [INT_ELEMS-1:0]             coll;

    assign ext_wr_vec = ext_wr_data;
    assign int_wr_vec = int_wr_data;

    for (genvar b = 0; b < INT_ELEMS; b++) begin : g_bank
        logic [LG-1:0]  ewr_k, erd_k, iwr_k, ird_k;
        logic [RAW-1:0] ewr_row, erd_row, iwr_row, ird_row;
        logic           ewr_hit;

        assign ewr_k   = lane_of(ext_wr_s[LG-1:0], b);
        assign erd_k   = lane_of(ext_rd_s[LG-1:0], b);
        assign iwr_k   = lane_of(int_wr_s[LG-1:0], b);
        assign ird_k   = lane_of(int_rd_s[LG-1:0], b);
        assign ewr_row = row_of(ext_wr_s, ewr_k);
        assign erd_row = row_of(ext_rd_s, erd_k);
        assign iwr_row = row_of(int_wr_s, iwr_k);
        assign ird_row = row_of(int_rd_s, ird_k);

        // Ext word only covers EXT_ELEMS lanes; the int access covers all.
        assign ewr_hit = ext_wr_ok && ({1'b0, ewr_k} < (LG+1)'(EXT_ELEMS));
        // Same bank and same row means the same element.
        assign coll[b] = ewr_hit && int_wr_ok && (ewr_row == iwr_row);

        qracc_actbuf_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS)
        ) u_bank (
            .clk       (clk),
            .nrst      (nrst),
            .wa_en_i   (int_wr_ok),
            .wa_row_i  (iwr_row),
            .wa_data_i (int_wr_vec[iwr_k]),
            .wb_en_i   (ewr_hit),
            .wb_row_i  (ewr_row),
            .wb_data_i (ext_wr_vec[EXT_IW'(ewr_k)]),
            .ra_en_i   (ext_rd_go && !ext_rd_oob),
            .ra_row_i  (erd_row),
            .ra_data_o (bank_ext_q[b]),
            .rb_en_i   (int_rd_go && !int_rd_oob),
            .rb_row_i  (ird_row),
            .rb_data_o (bank_int_q[b])
        );
    end

    // Read side-band and sticky errors.
    logic          ext_vld_q, int_vld_q;
    logic          ext_oob_q, int_oob_q;
    logic [LG-1:0] ext_rot_q, int_rot_q;
    actbuf_err_t   err_q, err_d;

    // Error next-state: clear wins, otherwise flags accumulate.
    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = '0;
        end else begin
            if ((ext_wr_en && ext_wr_oob) || (int_wr_en && int_wr_oob) ||
                (ext_rd_en && ext_rd_oob) || (int_rd_en && int_rd_oob))
                err_d.oob = 1'b1;
            if (|coll)
                err_d.collision = 1'b1;
        end
    end

    // Valid pipeline; rotation/oob only captured on issue so data holds.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ext_vld_q <= 1'b0;
            int_vld_q <= 1'b0;
            ext_oob_q <= 1'b0;
            int_oob_q <= 1'b0;
            ext_rot_q <= '0;
            int_rot_q <= '0;
            err_q     <= '0;
        end else begin
            ext_vld_q <= ext_rd_go;
            int_vld_q <= int_rd_go;
            if (ext_rd_go) begin
                ext_rot_q <= ext_rd_s[LG-1:0];
                ext_oob_q <= ext_rd_oob;
            end
            if (int_rd_go) begin
                int_rot_q <= int_rd_s[LG-1:0];
                int_oob_q <= int_rd_oob;
            end
            err_q <= err_d;
        end
    end

    // Rotate bank outputs into element order; out-of-range reads give zeros.
    always_comb begin
        logic [LG-1:0] idx;
        idx         = '0;
        ext_rd_data = '0;
        int_rd_data = '0;
        for (int k = 0; k < EXT_ELEMS; k++) begin
            idx = ext_rot_q + LG'(k);
            ext_rd_data[k*DATA_W +: DATA_W] = bank_ext_q[idx];
        end
        for (int k = 0; k < INT_ELEMS; k++) begin
            idx = int_rot_q + LG'(k);
            int_rd_data[k*DATA_W +: DATA_W] = bank_int_q[idx];
        end
        if (ext_oob_q) ext_rd_data = '0;
        if (int_oob_q) int_rd_data = '0;
    end

    assign ext_rd_valid = ext_vld_q;
    assign int_rd_valid = int_vld_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_qracc_activation_buffer.sv
// Bench for qracc_activation_buffer: directed scenarios plus random traffic,
// all checked against an element-array reference model.
module tb_qracc_activation_buffer;
    import qracc_pkg::*;

    localparam int DATA_W = 8;
    localparam int EXT_W  = 32;
    localparam int N      = 16;
    localparam int DEPTH  = 4096;
    localparam int AW     = 12;
    localparam int IW     = N * DATA_W;

    logic            clk = 1'b0;
    logic            nrst;
    logic            clear;
    logic            ext_wr_en, ext_rd_en, int_rd_en, int_wr_en;
    logic [AW-1:0]   ext_wr_addr, ext_rd_addr, int_rd_addr, int_wr_addr;
    logic [EXT_W-1:0] ext_wr_data, ext_rd_data;
    logic [IW-1:0]   int_wr_data, int_rd_data;
    logic            ext_rd_valid, int_rd_valid;
    actbuf_err_t     err_o;

    qracc_activation_buffer dut (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (clear),
        .ext_wr_en    (ext_wr_en),
        .ext_wr_addr  (ext_wr_addr),
        .ext_wr_data  (ext_wr_data),
        .ext_rd_en    (ext_rd_en),
        .ext_rd_addr  (ext_rd_addr),
        .ext_rd_data  (ext_rd_data),
        .ext_rd_valid (ext_rd_valid),
        .int_rd_en    (int_rd_en),
        .int_rd_addr  (int_rd_addr),
        .int_rd_data  (int_rd_data),
        .int_rd_valid (int_rd_valid),
        .int_wr_en    (int_wr_en),
        .int_wr_addr  (int_wr_addr),
        .int_wr_data  (int_wr_data),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0]       mem_m [DEPTH];
    logic [EXT_W-1:0] exp_ext_d;
    logic [IW-1:0]    exp_int_d;
    logic             exp_ext_v, exp_int_v;
    actbuf_err_t      exp_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear     = 1'b0;
        ext_wr_en = 1'b0;
        ext_rd_en = 1'b0;
        int_wr_en = 1'b0;
        int_rd_en = 1'b0;
    endtask

    // Predict one cycle from the current inputs, clock it, compare everything.
    task automatic step();
        int ew, iw, er, ir;
        bit ewo, iwo, ero, iro, coll, oob;
        ew  = int'(ext_wr_addr) * 4;
        er  = int'(ext_rd_addr) * 4;
        iw  = int'(int_wr_addr);
        ir  = int'(int_rd_addr);
        ewo = (ew + 4) > DEPTH;
        ero = (er + 4) > DEPTH;
        iwo = (iw + N) > DEPTH;
        iro = (ir + N) > DEPTH;
        // reads see memory before this cycle's writes
        if (ext_rd_en && !clear) begin
            exp_ext_v = 1'b1;
            exp_ext_d = '0;
            if (!ero) for (int k = 0; k < 4; k++) exp_ext_d[k*8 +: 8] = mem_m[er+k];
        end else exp_ext_v = 1'b0;
        if (int_rd_en && !clear) begin
            exp_int_v = 1'b1;
            exp_int_d = '0;
            if (!iro) for (int k = 0; k < N; k++) exp_int_d[k*8 +: 8] = mem_m[ir+k];
        end else exp_int_v = 1'b0;
        coll = ext_wr_en && int_wr_en && !ewo && !iwo && (ew < iw + N) && (iw < ew + 4);
        oob  = (ext_wr_en && ewo) || (int_wr_en && iwo) || (ext_rd_en && ero) || (int_rd_en && iro);
        if (ext_wr_en && !ewo) for (int k = 0; k < 4; k++) mem_m[ew+k] = ext_wr_data[k*8 +: 8];
        if (int_wr_en && !iwo) for (int k = 0; k < N; k++) mem_m[iw+k] = int_wr_data[k*8 +: 8];
        if (clear) exp_err = '0;
        else begin
            if (oob)  exp_err.oob = 1'b1;
            if (coll) exp_err.collision = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ext_rd_valid", IW'(ext_rd_valid), IW'(exp_ext_v));
        chk("int_rd_valid", IW'(int_rd_valid), IW'(exp_int_v));
        chk("ext_rd_data",  IW'(ext_rd_data),  IW'(exp_ext_d));
        chk("int_rd_data",  int_rd_data,       exp_int_d);
        chk("err_o",        IW'(err_o),        IW'(exp_err));
    endtask

    initial begin
        logic [IW-1:0] v;
        int t;
        nrst        = 1'b0;
        idle();
        ext_wr_addr = '0; ext_rd_addr = '0; int_wr_addr = '0; int_rd_addr = '0;
        ext_wr_data = '0; int_wr_data = '0;
        exp_ext_d   = '0; exp_int_d = '0; exp_ext_v = 1'b0; exp_int_v = 1'b0; exp_err = '0;

        // reset state
        #12;
        chk("rst_ext_valid", IW'(ext_rd_valid), '0);
        chk("rst_int_valid", IW'(int_rd_valid), '0);
        chk("rst_ext_data",  IW'(ext_rd_data),  '0);
        chk("rst_int_data",  int_rd_data,       '0);
        chk("rst_err",       IW'(err_o),        '0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // fill memory with random words so the model is fully defined
        for (int w = 0; w < DEPTH/4; w++) begin
            ext_wr_en = 1'b1; ext_wr_addr = AW'(w); ext_wr_data = $urandom;
            step();
        end
        // elements 0..31 = index
        for (int w = 0; w < 8; w++) begin
            ext_wr_addr = AW'(w);
            ext_wr_data = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            step();
        end
        idle();

        // 1: ext word read
        ext_rd_en = 1'b1; ext_rd_addr = 12'd2;
        step();
        chk("t1_ext_word", IW'(ext_rd_data), IW'(32'h0B0A0908));
        idle();
        step();
        chk("t1_valid_drop", IW'(ext_rd_valid), '0);
        chk("t1_data_hold", IW'(ext_rd_data), IW'(32'h0B0A0908));

        // 2: unaligned and aligned int reads
        int_rd_en = 1'b1; int_rd_addr = 12'd5;
        step();
        for (int k = 0; k < N; k++) v[k*8 +: 8] = 8'(5 + k);
        chk("t2_unaligned", int_rd_data, v);
        int_rd_addr = 12'd16;
        step();
        for (int k = 0; k < N; k++) v[k*8 +: 8] = 8'(16 + k);
        chk("t2_aligned", int_rd_data, v);
        idle();

        // 3: unaligned int write then read back
        int_wr_en = 1'b1; int_wr_addr = 12'd3;
        for (int k = 0; k < N; k++) int_wr_data[k*8 +: 8] = 8'(8'hA0 + k);
        step();
        idle();
        int_rd_en = 1'b1; int_rd_addr = 12'd0;
        step();
        for (int k = 0; k < N; k++) v[k*8 +: 8] = (k < 3) ? 8'(k) : 8'(8'hA0 + k - 3);
        chk("t3_int_rdback", int_rd_data, v);
        idle();
        ext_rd_en = 1'b1; ext_rd_addr = 12'd4;
        step();
        chk("t3_ext_rdback", IW'(ext_rd_data), IW'(32'h13AFAEAD));
        idle();

        // 4: collision between ext and int writes
        ext_wr_en = 1'b1; ext_wr_addr = 12'd1; ext_wr_data = 32'h11111111;
        int_wr_en = 1'b1; int_wr_addr = 12'd6; int_wr_data = {N{8'h22}};
        step();
        chk("t4_collision", IW'(err_o.collision), IW'(1'b1));
        idle();
        ext_rd_en = 1'b1; ext_rd_addr = 12'd1;
        step();
        chk("t4_merge", IW'(ext_rd_data), IW'(32'h22221111));
        idle();
        clear = 1'b1;
        step();
        chk("t4_clear", IW'(err_o), '0);
        idle();
        int_rd_en = 1'b1; int_rd_addr = 12'd6;
        step();
        chk("t4_int_span", int_rd_data, {N{8'h22}});
        idle();

        // 5: out-of-range accesses
        int_rd_en = 1'b1; int_rd_addr = 12'd4085;
        step();
        chk("t5_oob_zero", int_rd_data, '0);
        chk("t5_oob_valid", IW'(int_rd_valid), IW'(1'b1));
        chk("t5_oob_flag", IW'(err_o.oob), IW'(1'b1));
        idle();
        int_wr_en = 1'b1; int_wr_addr = 12'd4090; int_wr_data = {N{8'hEE}};
        step();
        idle();
        clear = 1'b1;
        step();
        idle();
        int_rd_en = 1'b1; int_rd_addr = 12'd4080;
        step();
        chk("t5_edge_no_oob", IW'(err_o.oob), '0);
        idle();

        // 6: read-first, clear vs rd_en, async reset
        ext_rd_en = 1'b1; ext_rd_addr = 12'd0;
        int_wr_en = 1'b1; int_wr_addr = 12'd0; int_wr_data = {$urandom, $urandom, $urandom, $urandom};
        step();
        chk("t6_read_first", IW'(ext_rd_data), IW'(32'hA0020100));
        idle();
        clear = 1'b1; ext_rd_en = 1'b1; int_rd_en = 1'b1;
        step();
        chk("t6_clear_kills_rd", IW'({ext_rd_valid, int_rd_valid}), '0);
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ext_wr_en   = ($urandom_range(0, 2) == 0);
            ext_rd_en   = ($urandom_range(0, 1) == 0);
            int_wr_en   = ($urandom_range(0, 2) == 0);
            int_rd_en   = ($urandom_range(0, 1) == 0);
            clear       = ($urandom_range(0, 24) == 0);
            ext_wr_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(1020, 4095)) : AW'($urandom_range(0, 1023));
            ext_rd_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(1020, 4095)) : AW'($urandom_range(0, 1023));
            int_rd_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(4070, 4095)) : AW'($urandom_range(0, 4080));
            if ($urandom_range(0, 2) == 0) begin
                t = int'(ext_wr_addr) * 4 - int'($urandom_range(0, 18));
                if (t < 0) t = 0;
                if (t > 4080) t = 4080;
                int_wr_addr = AW'(t);
            end else begin
                int_wr_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(4070, 4095)) : AW'($urandom_range(0, 4080));
            end
            ext_wr_data = $urandom;
            int_wr_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        idle();

        // async reset while a read result is on the outputs
        int_rd_en = 1'b1; int_rd_addr = 12'd7; ext_rd_en = 1'b1; ext_rd_addr = 12'd9;
        step();
        idle();
        nrst = 1'b0;
        #1;
        chk("t6_rst_ext_valid", IW'(ext_rd_valid), '0);
        chk("t6_rst_int_valid", IW'(int_rd_valid), '0);
        chk("t6_rst_int_data",  int_rd_data, '0);
        chk("t6_rst_err",       IW'(err_o), '0);
        exp_ext_v = 1'b0; exp_int_v = 1'b0; exp_ext_d = '0; exp_int_d = '0; exp_err = '0;
        #2;
        nrst = 1'b1;
        // memory survives reset
        int_rd_en = 1'b1; int_rd_addr = 12'd100;
        step();
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
